dpd_lut_loader: RTL

Sequencer that loads a full coefficient table into one of NUM_LUT DPD actuator lookup tables through their configuration ports, and optionally reads it back for verification. Coefficients arrive on a valid/ready stream. Writes are one word per accepted beat at ascending addresses. Read-back recomputes a running checksum and compares it with the checksum accumulated during the write. The block sits between the AXI register/DMA front end and the LUT bank of the DPD actuator, and owns the LUT config ports while busy.

---
 rtl/dpd_lut_loader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/dpd_lut_loader.sv
// Loads one full coefficient table into a selected DPD LUT over the shared config port,
// optionally reading it back and comparing a running checksum against the write checksum.
module dpd_lut_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int NUM_LUT    = 8,
    localparam int SEL_W     = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [SEL_W-1:0]              lut_sel,
    input  logic                          verify_en,
    input  logic                          abort,
    input  logic                          s_valid,
    input  logic [DATA_WIDTH-1:0]         s_data,
    output logic                          s_ready,
    output logic [ADDR_WIDTH-1:0]         cfg_addr,
    output logic [DATA_WIDTH-1:0]         cfg_din,
    output logic [NUM_LUT-1:0]            cfg_web,
    input  logic [NUM_LUT*DATA_WIDTH-1:0] cfg_dout,
    output logic                          busy,
    output logic                          done,
    output logic                          error,
    output logic [DATA_WIDTH-1:0]         checksum
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_RD_ISSUE,
        ST_RD_DRAIN,
        ST_CHECK
    } state_t;

    localparam logic [SEL_W:0] NUM_LUT_W = (SEL_W + 1)'(NUM_LUT);

    state_t                  state;
    state_t                  state_nxt;
    logic [SEL_W-1:0]        sel_q;
    logic                    verify_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wsum_q;
    logic [DATA_WIDTH-1:0]   rsum_q;
    logic                    rd_pend_q;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic                    start_acc;
    logic                    abort_acc;
    logic                    sel_bad;
    logic                    addr_last;
    logic                    wr_beat;
    logic                    rd_issue;

    assign start_acc = (state == ST_IDLE) && start;
    assign abort_acc = (state != ST_IDLE) && abort;
    assign sel_bad   = ({1'b0, lut_sel} >= NUM_LUT_W);
    assign addr_last = &addr_q;
    assign busy      = (state != ST_IDLE);
    assign checksum  = wsum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (start && !sel_bad) state_nxt = ST_WRITE;
            ST_WRITE:    if (wr_beat && addr_last) state_nxt = verify_q ? ST_RD_ISSUE : ST_CHECK;
            ST_RD_ISSUE: if (addr_last) state_nxt = ST_RD_DRAIN;
            ST_RD_DRAIN: state_nxt = ST_CHECK;
            ST_CHECK:    state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
        if (abort_acc) state_nxt = ST_IDLE;
    end

    // Stream handshake: a beat transfers in any cycle where s_valid and s_ready are both
    // high; s_ready is only raised in WRITE and is pulled low by abort in that same cycle.
    always_comb begin
        s_ready  = 1'b0;
        wr_beat  = 1'b0;
        rd_issue = 1'b0;
        cfg_addr = '0;
        cfg_din  = '0;
        cfg_web  = '0;
        case (state)
            ST_WRITE: begin
                s_ready  = !abort;
                wr_beat  = s_valid && !abort;
                cfg_addr = addr_q;
                if (wr_beat) begin
                    cfg_din = s_data;
                    for (int i = 0; i < NUM_LUT; i++) begin
                        cfg_web[i] = (sel_q == SEL_W'(i));
                    end
                end
            end
            ST_RD_ISSUE: begin
                rd_issue = !abort;
                cfg_addr = addr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_LUT; i++) begin
            if (sel_q == SEL_W'(i)) rd_word = cfg_dout[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // rd_pend_q marks the cycle in which the LUT returns data for last cycle's address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            verify_q  <= 1'b0;
            addr_q    <= '0;
            wsum_q    <= '0;
            rsum_q    <= '0;
            rd_pend_q <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done      <= 1'b0;
            rd_pend_q <= rd_issue;
            if (start_acc) begin
                sel_q    <= lut_sel;
                verify_q <= verify_en;
                addr_q   <= '0;
                wsum_q   <= '0;
                rsum_q   <= '0;
                error    <= sel_bad;
                done     <= sel_bad;
            end else if (abort_acc) begin
                addr_q <= '0;
                error  <= 1'b1;
                done   <= 1'b1;
            end else begin
                if (wr_beat) begin
                    wsum_q <= wsum_q + s_data;
                    addr_q <= addr_q + ADDR_WIDTH'(1);
                end
                if (rd_issue) addr_q <= addr_q + ADDR_WIDTH'(1);
                if (rd_pend_q) rsum_q <= rsum_q + rd_word;
                if (state == ST_CHECK) begin
                    done <= 1'b1;
                    if (verify_q && (rsum_q != wsum_q)) error <= 1'b1;
                end
            end
        end
    end

endmodule
